// File: rtl/shift_pkg.sv
// Shared types and defaults for the iterative shift sequencer.
// The package holds the op encodings, the controller state set and the default widths.
package shift_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // The reserved encoding behaves as SLL, including lost-bit tracking.
    function automatic logic is_left(input logic [1:0] op);
        return !((shift_op_e'(op) == OP_SRL) || (shift_op_e'(op) == OP_SRA));
    endfunction

endpackage

// File: rtl/shift_one_step.sv
// One-position shift stage: SLL, SRL or SRA by a single bit.
// out_bit is the bit that falls off the end in the shift direction.
module shift_one_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             out_bit
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        dout    = {din[WIDTH-2:0], 1'b0};
        out_bit = din[WIDTH-1];
        case (shift_op_e'(op))
            OP_SRL: begin
                dout    = {1'b0, din[WIDTH-1:1]};
                out_bit = din[0];
            end
            OP_SRA: begin
                dout    = {din[WIDTH-1], din[WIDTH-1:1]};
                out_bit = din[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/iter_shift_ctrl.sv
// Multi-cycle shift sequencer: drives one 1-bit shift stage per clock until the
// requested amount is consumed, then publishes the result with a done pulse.
module iter_shift_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               abort,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               lost
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [1:0]         op_q;
    logic               lost_acc_q;
    logic               ready_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               lost_q;

    logic [WIDTH-1:0]   step_out;
    logic               step_bit;

    shift_one_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op      (op_q),
        .din     (work_q),
        .dout    (step_out),
        .out_bit (step_bit)
    );

    // Next-state logic; abort only matters while shifting, and beats a final shift.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q <= SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            work_q     <= '0;
            cnt_q      <= '0;
            op_q       <= 2'b00;
            lost_acc_q <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            lost_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        work_q     <= data_in;
                        cnt_q      <= shamt;
                        op_q       <= op;
                        lost_acc_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!abort) begin
                        work_q <= step_out;
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - SHAMT_W'(1);
                        end
                        if (is_left(op_q)) begin
                            lost_acc_q <= lost_acc_q | step_bit;
                        end
                    end
                end
                DONE: begin
                    done_q   <= 1'b1;
                    result_q <= work_q;
                    lost_q   <= is_left(op_q) & lost_acc_q;
                end
                default: ;
            endcase
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;
    assign lost   = lost_q;

endmodule
